// File: rtl/miniRISC_pkg.sv
// Shared definitions for the data-memory inspector: FSM state encoding and
// the readout mode codes driven on the mode input.
package miniRISC_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } insp_state_t;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF  = 2'b00;
    localparam mode_t MODE_STEP = 2'b01;
    localparam mode_t MODE_AUTO = 2'b10;

    // True when the mode code is one that can generate reads (11 behaves as off).
    function automatic logic mode_active(input mode_t m);
        logic act;
        case (m)
            MODE_STEP, MODE_AUTO: act = 1'b1;
            MODE_OFF:             act = 1'b0;
            default:              act = 1'b0;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchroniser for an asynchronous level (SYNC_STG flops) followed by a
// rising-edge detector producing a one-cycle pulse on clk.
module sync_edge_detect #(
    parameter int SYNC_STG = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic [SYNC_STG-1:0] sync_reg;
    logic                prev_reg;

    // Shift the raw input through the synchroniser chain; stage 0 sees the async level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg[0] <= sig;
            for (int i = 1; i < SYNC_STG; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    // Remember the previous synchronised level for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_reg <= 1'b0;
        end else begin
            prev_reg <= sync_reg[SYNC_STG-1];
        end
    end

    assign rise = sync_reg[SYNC_STG-1] & ~prev_reg;

endmodule

// File: rtl/data_mem_inspector.sv
// Memory readout inspector. Sits between the CPU data port and the data BRAM,
// borrows the port for one ISSUE cycle per read, and latches each word it reads
// into final_result while walking a wrapping pointer through memory.
module data_mem_inspector
    import miniRISC_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int DEPTH    = 1024,
    parameter int BRAM_LAT = 1,
    parameter int SCAN_DIV = 1000,
    parameter int SYNC_STG = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              button,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_en,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] final_result,
    output logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_valid
);

    localparam int                SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);
    // WAIT lasts BRAM_LAT-1 cycles; the counter runs 0..BRAM_LAT-2 inside it.
    localparam logic [1:0]        WAIT_LAST = 2'((BRAM_LAT > 1) ? BRAM_LAT - 2 : 0);

    insp_state_t       state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg;
    logic              pending_reg, pending_next;
    logic [SCAN_W-1:0] scan_cnt_reg;
    logic [1:0]        wait_cnt_reg, wait_cnt_next;

    logic step_pulse;
    logic step_req;
    logic auto_req;
    logic request;
    logic active;
    logic start;
    logic capture;

    sync_edge_detect #(
        .SYNC_STG (SYNC_STG)
    ) u_button_sync (
        .clk  (clk),
        .rst  (rst),
        .sig  (button),
        .rise (step_pulse)
    );

    assign active   = mode_active(mode);
    assign step_req = (mode == MODE_STEP) && step_pulse;
    assign auto_req = (mode == MODE_AUTO) && (scan_cnt_reg == SCAN_LAST);
    assign request  = step_req || auto_req;

    // Auto-scan divider: free-runs 0..SCAN_DIV-1 in auto mode, parked at 0 otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_reg <= '0;
        end else if (mode != MODE_AUTO) begin
            scan_cnt_reg <= '0;
        end else if (scan_cnt_reg == SCAN_LAST) begin
            scan_cnt_reg <= '0;
        end else begin
            scan_cnt_reg <= scan_cnt_reg + 1'b1;
        end
    end

    // Next-state logic: IDLE -> ISSUE -> (WAIT) -> CAPTURE -> IDLE.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        start         = 1'b0;
        capture       = 1'b0;
        unique case (state_reg)
            IDLE: begin
                // A held-over request is only honoured while a reading mode is selected.
                if (request || (pending_reg && active)) begin
                    start      = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                wait_cnt_next = '0;
                state_next    = (BRAM_LAT == 1) ? CAPTURE : WAIT;
            end
            WAIT: begin
                if (wait_cnt_reg == WAIT_LAST) begin
                    state_next = CAPTURE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 2'd1;
                end
            end
            CAPTURE: begin
                capture    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One-deep pending flag: holds a request that arrived while busy; extra ones are dropped.
    always_comb begin
        pending_next = pending_reg;
        if (!active || start) begin
            pending_next = 1'b0;
        end else if (request && (state_reg != IDLE)) begin
            pending_next = 1'b1;
        end
    end

    // FSM, wait counter, pending flag and read pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            pending_reg  <= 1'b0;
            ptr_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            pending_reg  <= pending_next;
            if (capture) begin
                ptr_reg <= (ptr_reg == PTR_LAST) ? '0 : ptr_reg + 1'b1;
            end
        end
    end

    // Capture registers: the dbg_valid pulse coincides with the new final_result value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            final_result <= '0;
            dbg_addr     <= '0;
            dbg_valid    <= 1'b0;
        end else begin
            dbg_valid <= capture;
            if (capture) begin
                final_result <= mem_rdata;
                dbg_addr     <= ptr_reg;
            end
        end
    end

    // Port mux: the inspector owns the BRAM port only in ISSUE; otherwise the CPU passes straight through.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_en    = cpu_en;
        mem_we    = cpu_we;
        mem_wdata = cpu_wdata;
        cpu_stall = 1'b0;
        if (state_reg == ISSUE) begin
            mem_addr  = ptr_reg;
            mem_en    = 1'b1;
            mem_we    = 1'b0;
            mem_wdata = '0;
            cpu_stall = 1'b1;
        end
    end

endmodule

// File: tb/tb_data_mem_inspector.sv
// Directed bench for data_mem_inspector: one instance with a 1-cycle BRAM (DEPTH 4)
// and one with a 3-cycle BRAM (DEPTH 8), driven by the same button/mode/CPU stimulus.
module tb_data_mem_inspector;

    localparam int DW = 32;
    localparam int AW = 10;

    typedef struct {
        int             cyc;
        logic [DW-1:0]  data;
        logic [AW-1:0]  addr;
    } cap_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          button = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [AW-1:0] cpu_addr = '0;
    logic          cpu_en = 1'b0;
    logic          cpu_we = 1'b0;
    logic [DW-1:0] cpu_wdata = '0;

    logic [AW-1:0] mem_addr_a, mem_addr_b, dbg_addr_a, dbg_addr_b;
    logic          mem_en_a, mem_en_b, mem_we_a, mem_we_b;
    logic [DW-1:0] mem_wdata_a, mem_wdata_b, mem_rdata_a, mem_rdata_b;
    logic [DW-1:0] final_result_a, final_result_b;
    logic          cpu_stall_a, cpu_stall_b, dbg_valid_a, dbg_valid_b;

    logic [DW-1:0] ram_a [0:(1<<AW)-1];
    logic [DW-1:0] ram_b [0:(1<<AW)-1];
    logic [DW-1:0] rd_a, rd_b1, rd_b2, rd_b3;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_stall_a = 0;
    int   t_ref;
    bit   found;
    cap_t cap_a[$];
    cap_t cap_b[$];

    always #5 clk = ~clk;

    data_mem_inspector #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(4), .BRAM_LAT(1), .SCAN_DIV(8), .SYNC_STG(2)
    ) u_a (
        .clk(clk), .rst(rst), .button(button), .mode(mode),
        .cpu_addr(cpu_addr), .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .mem_addr(mem_addr_a), .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_wdata(mem_wdata_a),
        .mem_rdata(mem_rdata_a), .cpu_stall(cpu_stall_a), .final_result(final_result_a),
        .dbg_addr(dbg_addr_a), .dbg_valid(dbg_valid_a)
    );

    data_mem_inspector #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(8), .BRAM_LAT(3), .SCAN_DIV(8), .SYNC_STG(2)
    ) u_b (
        .clk(clk), .rst(rst), .button(button), .mode(mode),
        .cpu_addr(cpu_addr), .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .mem_addr(mem_addr_b), .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata_b), .cpu_stall(cpu_stall_b), .final_result(final_result_b),
        .dbg_addr(dbg_addr_b), .dbg_valid(dbg_valid_b)
    );

    // Preload: ram_a[i] = A0+i (i<4), ram_b[i] = B0+i (i<8), everything else 0.
    initial begin
        for (int i = 0; i < (1<<AW); i++) begin
            ram_a[i] <= '0;
            ram_b[i] <= '0;
        end
        for (int i = 0; i < 4; i++) ram_a[i] <= 32'h0000_00A0 + 32'(i);
        for (int i = 0; i < 8; i++) ram_b[i] <= 32'h0000_00B0 + 32'(i);
    end

    // BRAM models: read-first, 1-cycle latency for a, 3-cycle for b.
    always @(posedge clk) begin
        if (mem_en_a) begin
            if (mem_we_a) ram_a[mem_addr_a] <= mem_wdata_a;
            rd_a <= ram_a[mem_addr_a];
        end
        if (mem_en_b) begin
            if (mem_we_b) ram_b[mem_addr_b] <= mem_wdata_b;
            rd_b1 <= ram_b[mem_addr_b];
        end
        rd_b2 <= rd_b1;
        rd_b3 <= rd_b2;
    end
    assign mem_rdata_a = rd_a;
    assign mem_rdata_b = rd_b3;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every capture and every stall cycle, sampled mid-cycle.
    always @(negedge clk) begin
        cap_t e;
        if (dbg_valid_a) begin
            e.cyc = cyc; e.data = final_result_a; e.addr = dbg_addr_a;
            cap_a.push_back(e);
            $display("[%0d] a capture addr=%0d data=%08h", cyc, dbg_addr_a, final_result_a);
        end
        if (dbg_valid_b) begin
            e.cyc = cyc; e.data = final_result_b; e.addr = dbg_addr_b;
            cap_b.push_back(e);
            $display("[%0d] b capture addr=%0d data=%08h", cyc, dbg_addr_b, final_result_b);
        end
        if (cpu_stall_a) n_stall_a++;
    end

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_cap(input string tag, input bit inst_b, input int idx,
                             input logic [DW-1:0] d, input logic [AW-1:0] a);
        cap_t e;
        int sz;
        sz = inst_b ? cap_b.size() : cap_a.size();
        check_value({tag, "_present"}, 64'(sz > idx), 64'd1);
        if (sz > idx) begin
            e = inst_b ? cap_b[idx] : cap_a[idx];
            check_value({tag, "_data"}, 64'(e.data), 64'(d));
            check_value({tag, "_addr"}, 64'(e.addr), 64'(a));
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        button = 1'b1;
        step(4);
        button = 1'b0;
        step(6);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        cap_a.delete();
        cap_b.delete();
        n_stall_a = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(3);
        check_value("rst_final_a", 64'(final_result_a), 64'd0);
        check_value("rst_dbg_addr_a", 64'(dbg_addr_a), 64'd0);
        check_value("rst_dbg_valid_a", 64'(dbg_valid_a), 64'd0);
        check_value("rst_stall_a", 64'(cpu_stall_a), 64'd0);
        check_value("rst_final_b", 64'(final_result_b), 64'd0);
        rst = 1'b0;
        step(2);

        // 1: three step presses read A0..A2; press to dbg_valid = 2 sync + LAT + 2 cycles
        mode = 2'b01;
        t_ref = cyc;
        repeat (3) press();
        step(10);
        check_value("t1_count_a", 64'(cap_a.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            check_cap("t1_a", 1'b0, i, 32'h0000_00A0 + 32'(i), AW'(i));
        check_value("t1_count_b", 64'(cap_b.size()), 64'd3);
        check_cap("t1_b2", 1'b1, 2, 32'h0000_00B2, 10'd2);
        if (cap_a.size() > 0) check_value("t1_lat_a", 64'(cap_a[0].cyc - t_ref), 64'd5);
        if (cap_b.size() > 0) check_value("t1_lat_b", 64'(cap_b[0].cyc - t_ref), 64'd7);

        // 2: pointer wraps at DEPTH-1 (a: DEPTH 4), b keeps going to address 4
        do_reset();
        repeat (5) press();
        step(10);
        check_value("t2_count_a", 64'(cap_a.size()), 64'd5);
        check_cap("t2_a3", 1'b0, 3, 32'h0000_00A3, 10'd3);
        check_cap("t2_a4", 1'b0, 4, 32'h0000_00A0, 10'd0);
        check_cap("t2_b4", 1'b1, 4, 32'h0000_00B4, 10'd4);

        // 3: auto scan, SCAN_DIV 8, 40 clocks -> 5 captures spaced by 8
        mode = 2'b00;
        do_reset();
        mode = 2'b10;
        t_ref = cyc;
        step(40);
        mode = 2'b00;
        step(20);
        check_value("t3_count_a", 64'(cap_a.size()), 64'd5);
        check_value("t3_count_b", 64'(cap_b.size()), 64'd5);
        if (cap_a.size() > 0) check_value("t3_first_a", 64'(cap_a[0].cyc - t_ref), 64'd10);
        if (cap_b.size() > 0) check_value("t3_first_b", 64'(cap_b[0].cyc - t_ref), 64'd12);
        for (int i = 1; i < cap_a.size(); i++)
            check_value($sformatf("t3_space_a%0d", i), 64'(cap_a[i].cyc - cap_a[i-1].cyc), 64'd8);
        check_cap("t3_a4", 1'b0, 4, 32'h0000_00A0, 10'd0);

        // 4: CPU write held through a request: stalled only in ISSUE, write lands next cycle
        do_reset();
        mode = 2'b01;
        cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = 10'd2; cpu_wdata = 32'hC0FF_EE02;
        button = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1);
            if (cpu_stall_a) found = 1'b1;
        end
        check_value("t4_stall_seen", 64'(found), 64'd1);
        check_value("t4_issue_addr", 64'(mem_addr_a), 64'd0);
        check_value("t4_issue_we", 64'(mem_we_a), 64'd0);
        check_value("t4_issue_en", 64'(mem_en_a), 64'd1);
        step(1);
        button = 1'b0;
        check_value("t4_post_stall", 64'(cpu_stall_a), 64'd0);
        check_value("t4_post_we", 64'(mem_we_a), 64'd1);
        check_value("t4_post_addr", 64'(mem_addr_a), 64'd2);
        check_value("t4_post_wdata", 64'(mem_wdata_a), 64'hC0FF_EE02);
        step(10);
        check_value("t4_stall_cycles", 64'(n_stall_a), 64'd1);
        cpu_en = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (2) press();
        step(5);
        check_cap("t4_a0", 1'b0, 0, 32'h0000_00A0, 10'd0);
        check_cap("t4_a2", 1'b0, 2, 32'hC0FF_EE02, 10'd2);

        // 5: presses 2 cycles apart, third while pending -> b: two captures LAT+2 apart
        do_reset();
        button = 1'b1; step(1); button = 1'b0; step(1);
        button = 1'b1; step(1); button = 1'b0; step(1);
        button = 1'b1; step(1); button = 1'b0; step(15);
        check_value("t5_count_b", 64'(cap_b.size()), 64'd2);
        if (cap_b.size() > 1) check_value("t5_space_b", 64'(cap_b[1].cyc - cap_b[0].cyc), 64'd5);
        check_cap("t5_b1", 1'b1, 1, 32'h0000_00B1, 10'd1);
        check_value("t5_count_a", 64'(cap_a.size()), 64'd3);
        if (cap_a.size() > 1) check_value("t5_space_a", 64'(cap_a[1].cyc - cap_a[0].cyc), 64'd3);

        // 6: reset during b's WAIT clears everything at once; next read starts at 0
        button = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1);
            if (cpu_stall_b) found = 1'b1;
        end
        check_value("t6_stall_seen", 64'(found), 64'd1);
        button = 1'b0;
        step(1);
        rst = 1'b1;
        cap_a.delete();
        cap_b.delete();
        #1;
        check_value("t6_final_b", 64'(final_result_b), 64'd0);
        check_value("t6_dbg_addr_b", 64'(dbg_addr_b), 64'd0);
        check_value("t6_dbg_valid_b", 64'(dbg_valid_b), 64'd0);
        check_value("t6_stall_b", 64'(cpu_stall_b), 64'd0);
        check_value("t6_mem_en_b", 64'(mem_en_b), 64'd0);
        check_value("t6_final_a", 64'(final_result_a), 64'd0);
        step(2);
        rst = 1'b0;
        step(12);
        check_value("t6_no_capture_b", 64'(cap_b.size()), 64'd0);
        press();
        step(5);
        check_cap("t6_b0", 1'b1, 0, 32'h0000_00B0, 10'd0);

        // 7: switching to off mid-read completes the read but drops the pending request
        cap_a.delete();
        cap_b.delete();
        button = 1'b1; step(1); button = 1'b0; step(1);
        button = 1'b1; step(1); button = 1'b0; step(2);
        mode = 2'b00;
        step(12);
        check_value("t7_count_a", 64'(cap_a.size()), 64'd1);
        check_value("t7_count_b", 64'(cap_b.size()), 64'd1);

        // 8: mode 11 behaves as off
        cap_a.delete();
        cap_b.delete();
        mode = 2'b11;
        press();
        step(8);
        check_value("t8_mode11_a", 64'(cap_a.size()), 64'd0);
        check_value("t8_mode11_b", 64'(cap_b.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
